instr_fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_reg.sv | 25 ++
 rtl/instr_fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode field position, HALT opcode, fetch FSM states.
// Used by both the fetch stage and Control_unit so the instruction format has a single definition.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  localparam logic [3:0] CPU_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [CPU_INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to RESET_PC, load has priority over increment, wraps mod 2^ADDR_W.
// Single-cycle update; no backpressure of its own, the fetch FSM decides when it moves.
module pc_reg #(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: req/ack reads from instruction memory into an instruction register for decode.
// Two cycles minimum per instruction; req held until ack, instruction held while instr_ready is low.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = CPU_ADDR_W,
  parameter int                INSTR_W     = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = CPU_HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t state, state_nxt;
  logic         is_halt_op;
  logic         pc_inc;
  logic         pc_load;

  assign is_halt_op = (instruction[OPC_HI:OPC_LO] == HALT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nxt = ST_HOLD;
      ST_HOLD:  if (instr_ready) state_nxt = is_halt_op ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Valid/halted are pure state decodes, so an async reset clears them together with state.
  always_comb begin
    imem_req    = (state == ST_FETCH);
    instr_valid = (state == ST_HOLD);
    halted      = (state == ST_HALT);
    pc_inc      = (state == ST_FETCH) && imem_ack;
    pc_load     = (state == ST_HOLD) && instr_ready && !is_halt_op && pc_jump;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= '0;
    end else if (state == ST_FETCH && imem_ack) begin
      instruction <= imem_rdata;
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (jump_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign imem_addr = pc;

endmodule
